// File: rtl/ic_burst_pkg.sv
// Shared definitions for the Avalon-MM burst masters (write master, and later the read master).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: bus widths, the burst-master state encoding and the Avalon maximum burst size
// used to range-check the BURST_LENGTH parameter at elaboration.
package ic_burst_pkg;

    localparam int IC_ADDR_W           = 32;
    localparam int IC_DATA_W           = 32;
    // Word-count width: a byte length of IC_ADDR_W bits holds at most 2^30 words.
    localparam int IC_WORDS_W          = IC_ADDR_W - 2;
    // Avalon burstcount is 8 bits wide; 128 is the largest burst the interconnect accepts.
    localparam int IC_BURST_W          = 8;
    localparam int IC_AVALON_MAX_BURST = 128;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_FF = 2'd1,
        ST_BURST   = 2'd2,
        ST_DONE    = 2'd3
    } ic_state_e;

endpackage

// File: rtl/ic_burst_sizer.sv
// Sizes the next Avalon burst: min(words_left, BURST_LENGTH) beats and the matching byte stride.
// Latency: purely combinational.
// Backpressure: none; the caller samples the outputs when it launches a burst.
//
// Ports:
//   words_left_i  words still to transfer
//   beats_o       beat count of the next burst (never 0 while words_left_i != 0)
//   stride_o      beats_o * ADDRESS_INC, the byte distance to the following burst
module ic_burst_sizer
    import ic_burst_pkg::*;
#(
    parameter int BURST_LENGTH = 64,
    parameter int ADDRESS_INC  = 4
) (
    input  logic [IC_WORDS_W-1:0] words_left_i,
    output logic [IC_BURST_W-1:0] beats_o,
    output logic [IC_ADDR_W-1:0]  stride_o
);

    localparam logic [IC_WORDS_W-1:0] MAX_WORDS = IC_WORDS_W'(BURST_LENGTH);

    always_comb begin
        if (words_left_i < MAX_WORDS) begin
            // Below the cap the count fits in the burstcount width.
            beats_o = words_left_i[IC_BURST_W-1:0];
        end else begin
            beats_o = IC_BURST_W'(BURST_LENGTH);
        end
        stride_o = IC_ADDR_W'(beats_o) * IC_ADDR_W'(ADDRESS_INC);
    end

endmodule

// File: rtl/ic_master_write_burst.sv
// Avalon-MM burst write master draining a show-ahead FIFO into a contiguous word region.
// Latency: first oWrite 2 cycles after iStart with a full FIFO; oDone one cycle after the DONE state.
// Backpressure: iWait_request holds the current beat (no pop); a burst is only issued once the FIFO holds all of it.
//
// Ports:
//   iClk, iReset          clock, asynchronous active-high reset
//   iStart                one-cycle start pulse, honoured only in IDLE
//   iStart_write_address  word-aligned first byte address
//   iLength               transfer length in bytes (bits [1:0] ignored)
//   iWait_request         Avalon slave stall
//   iFF_usedw             FIFO fill level in words
//   iFF_read_data         FIFO head word (show-ahead)
//   oWrite                Avalon write strobe
//   oWrite_address        burst base address, constant during a burst
//   oBurst_length         burst beat count, constant during a burst
//   oWrite_data           FIFO head passed straight through
//   oFF_read_request      FIFO pop, one per accepted beat
//   oBusy                 high outside IDLE
//   oDone                 one-cycle completion pulse
module ic_master_write_burst
    import ic_burst_pkg::*;
#(
    parameter int BURST_LENGTH   = 64,
    parameter int ADDRESS_INC    = 4,
    parameter int FF_USEDW_WIDTH = 9
) (
    input  logic                      iClk,
    input  logic                      iReset,
    input  logic                      iStart,
    input  logic [IC_ADDR_W-1:0]      iStart_write_address,
    input  logic [IC_ADDR_W-1:0]      iLength,
    input  logic                      iWait_request,
    input  logic [FF_USEDW_WIDTH-1:0] iFF_usedw,
    input  logic [IC_DATA_W-1:0]      iFF_read_data,
    output logic                      oWrite,
    output logic [IC_ADDR_W-1:0]      oWrite_address,
    output logic [IC_BURST_W-1:0]     oBurst_length,
    output logic [IC_DATA_W-1:0]      oWrite_data,
    output logic                      oFF_read_request,
    output logic                      oBusy,
    output logic                      oDone
);

    if (BURST_LENGTH < 1 || BURST_LENGTH > IC_AVALON_MAX_BURST) begin : g_bad_burst_length
        $error("ic_master_write_burst: BURST_LENGTH must be within 1..128");
    end

    ic_state_e               state_q,      state_d;
    logic [IC_ADDR_W-1:0]    addr_q,       addr_d;
    logic [IC_BURST_W-1:0]   burst_len_q,  burst_len_d;
    logic [IC_ADDR_W-1:0]    stride_q,     stride_d;
    logic [IC_BURST_W-1:0]   beat_cnt_q,   beat_cnt_d;
    logic [IC_WORDS_W-1:0]   words_left_q, words_left_d;
    logic                    write_q,      write_d;
    logic                    done_q,       done_d;

    logic [IC_BURST_W-1:0]   beats;
    logic [IC_ADDR_W-1:0]    stride;
    logic [IC_WORDS_W-1:0]   start_words;
    logic                    beat_acc;
    logic                    ff_has_burst;
    logic                    unused_len_bits;

    // Sub-word length bits carry no meaning for a word-granular master.
    assign start_words     = iLength[IC_ADDR_W-1:2];
    assign unused_len_bits = ^iLength[1:0];

    ic_burst_sizer #(
        .BURST_LENGTH (BURST_LENGTH),
        .ADDRESS_INC  (ADDRESS_INC)
    ) u_sizer (
        .words_left_i (words_left_q),
        .beats_o      (beats),
        .stride_o     (stride)
    );

    assign beat_acc     = write_q & ~iWait_request;
    assign ff_has_burst = (32'(iFF_usedw) >= 32'(beats));

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        burst_len_d  = burst_len_q;
        stride_d     = stride_q;
        beat_cnt_d   = beat_cnt_q;
        words_left_d = words_left_q;
        write_d      = write_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    addr_d       = iStart_write_address;
                    words_left_d = start_words;
                    state_d      = (start_words == '0) ? ST_DONE : ST_WAIT_FF;
                end
            end

            ST_WAIT_FF: begin
                // Launch only when the whole burst is already buffered, so no beat can starve.
                if (ff_has_burst) begin
                    burst_len_d = beats;
                    beat_cnt_d  = beats;
                    // The stride is frozen at launch: words_left moves during the burst.
                    stride_d    = stride;
                    write_d     = 1'b1;
                    state_d     = ST_BURST;
                end
            end

            ST_BURST: begin
                if (beat_acc) begin
                    beat_cnt_d   = beat_cnt_q - 1'b1;
                    words_left_d = words_left_q - 1'b1;
                    if (beat_cnt_q == IC_BURST_W'(1)) begin
                        write_d = 1'b0;
                        // 32-bit wrap is intentional; no overflow is reported.
                        addr_d  = addr_q + stride_q;
                        state_d = (words_left_q == IC_WORDS_W'(1)) ? ST_DONE : ST_WAIT_FF;
                    end
                end
            end

            ST_DONE: begin
                done_d      = 1'b1;
                addr_d      = '0;
                burst_len_d = '0;
                stride_d    = '0;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            burst_len_q  <= '0;
            stride_q     <= '0;
            beat_cnt_q   <= '0;
            words_left_q <= '0;
            write_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            burst_len_q  <= burst_len_d;
            stride_q     <= stride_d;
            beat_cnt_q   <= beat_cnt_d;
            words_left_q <= words_left_d;
            write_q      <= write_d;
            done_q       <= done_d;
        end
    end

    assign oWrite           = write_q;
    assign oWrite_address   = addr_q;
    assign oBurst_length    = burst_len_q;
    assign oWrite_data      = iFF_read_data;
    assign oFF_read_request = beat_acc;
    assign oBusy            = (state_q != ST_IDLE);
    assign oDone            = done_q;

endmodule
